rep_window_monitor: RTL and testbench

- Synthesizable run-time checker for the bounded non-consecutive repetition property "$rose(trig) |-> evt[->MIN:MAX]" within a fixed cycle window.
- Strong semantics: a window that is still pending at end-of-test fails.
- Instantiated beside the trig/evt handshake under test; feeds the status/scoreboard logic.
- Reports pass/fail as one-cycle pulses plus saturating totals.

---
 rtl/rep_window_monitor.sv | 156 +++++++++++++++
 tb/tb_rep_window_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rep_window_monitor.sv
// rep_window_monitor
// Run-time checker for "$rose(trig) |-> evt[->MIN:MAX]" inside a window of
// TIMEOUT cycles (trigger cycle included). Strong semantics: eot closes any
// pending window with a verdict. Verdicts are one-cycle registered pulses;
// totals saturate at 16'hFFFF.
module rep_window_monitor #(
  parameter int MIN     = 1,
  parameter int MAX     = 3,
  parameter int TIMEOUT = 16,
  parameter int STRICT  = 0,
  parameter int CW      = $clog2(MAX + 2),
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          trig,
  input  logic          evt,
  input  logic          eot,
  output logic          pass,
  output logic          fail,
  output logic          busy,
  output logic [CW-1:0] evt_count,
  output logic [15:0]   pass_total,
  output logic [15:0]   fail_total,
  output logic [15:0]   drop_total
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_EXTEND = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_SAT = '1;
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX);
  localparam logic [TW-1:0] TMR_END = TW'(TIMEOUT - 1);
  localparam logic [15:0]   TOT_SAT = 16'hFFFF;

  state_t        r_state;
  state_t        w_state_d;
  logic          r_trig_q;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic          r_pass;
  logic          r_fail;
  logic          w_pass_d;
  logic          w_fail_d;
  logic [15:0]   r_pass_total;
  logic [15:0]   r_fail_total;
  logic [15:0]   r_drop_total;

  logic          w_rise;
  logic          w_busy;
  logic          w_active;
  logic          w_win_end;
  logic          w_drop;
  logic [CW-1:0] w_base_cnt;
  logic [TW-1:0] w_base_tmr;
  logic [CW-1:0] w_cnt_inc;

  // The trigger edge is evaluated exactly like a busy edge, starting from a
  // zero count and zero timer, so a window can decide on its first edge.
  assign w_rise     = trig & ~r_trig_q;
  assign w_busy     = (r_state != S_IDLE);
  assign w_active   = w_busy ? en : (w_rise & en);
  assign w_base_cnt = w_busy ? r_cnt : '0;
  assign w_base_tmr = w_busy ? r_timer : '0;
  assign w_cnt_inc  = (evt && (w_base_cnt != CNT_SAT)) ? w_base_cnt + CW'(1) : w_base_cnt;
  assign w_win_end  = (w_base_tmr == TMR_END);
  assign w_drop     = w_busy & w_rise;

  // Next-state and verdict decision: count evt first, then MIN/MAX, then
  // window end / eot.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_timer_d = r_timer;
    w_pass_d  = 1'b0;
    w_fail_d  = 1'b0;
    if (w_busy && !en) begin
      w_state_d = S_IDLE;
    end else if (w_active) begin
      w_cnt_d   = w_cnt_inc;
      w_timer_d = w_base_tmr + TW'(1);
      if (STRICT != 0) begin
        if (w_cnt_inc > CNT_MAX) begin
          w_fail_d  = 1'b1;
          w_state_d = S_IDLE;
        end else if (w_win_end || eot) begin
          w_pass_d  = (w_cnt_inc >= CNT_MIN);
          w_fail_d  = (w_cnt_inc <  CNT_MIN);
          w_state_d = S_IDLE;
        end else begin
          w_state_d = (w_cnt_inc >= CNT_MIN) ? S_EXTEND : S_COUNT;
        end
      end else begin
        if (w_cnt_inc >= CNT_MIN) begin
          w_pass_d  = 1'b1;
          w_state_d = S_IDLE;
        end else if (w_win_end || eot) begin
          w_fail_d  = 1'b1;
          w_state_d = S_IDLE;
        end else begin
          w_state_d = S_COUNT;
        end
      end
    end
  end

  // State, window bookkeeping and verdict pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_trig_q <= 1'b0;
      r_timer  <= '0;
      r_cnt    <= '0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state_d;
      r_trig_q <= trig;
      r_timer  <= w_timer_d;
      r_cnt    <= w_cnt_d;
      r_pass   <= w_pass_d;
      r_fail   <= w_fail_d;
    end
  end

  // Saturating pass/fail/drop totals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_total <= '0;
      r_fail_total <= '0;
      r_drop_total <= '0;
    end else begin
      if (w_pass_d && (r_pass_total != TOT_SAT)) r_pass_total <= r_pass_total + 16'd1;
      if (w_fail_d && (r_fail_total != TOT_SAT)) r_fail_total <= r_fail_total + 16'd1;
      if (w_drop   && (r_drop_total != TOT_SAT)) r_drop_total <= r_drop_total + 16'd1;
    end
  end

  assign pass       = r_pass;
  assign fail       = r_fail;
  assign busy       = w_busy;
  assign evt_count  = r_cnt;
  assign pass_total = r_pass_total;
  assign fail_total = r_fail_total;
  assign drop_total = r_drop_total;

endmodule

// File: tb/tb_rep_window_monitor.sv
// tb_rep_window_monitor
// Three monitors share one stimulus: first-match MIN=1 (fm), full-window
// STRICT=1 (st) and first-match MIN=2 (m2). Edge 1 is the first rising edge
// after reset release; outputs are sampled 1 ns after each edge.
module tb_rep_window_monitor;

  logic clk = 1'b0;
  logic rst_n, en, trig, evt, eot;

  logic fm_pass, fm_fail, fm_busy; logic [2:0] fm_cnt;
  logic [15:0] fm_pt, fm_ft, fm_dt;
  logic st_pass, st_fail, st_busy; logic [2:0] st_cnt;
  logic [15:0] st_pt, st_ft, st_dt;
  logic m2_pass, m2_fail, m2_busy; logic [2:0] m2_cnt;
  logic [15:0] m2_pt, m2_ft, m2_dt;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  rep_window_monitor #(.MIN(1), .MAX(3), .TIMEOUT(16), .STRICT(0)) u_fm (
    .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .evt(evt), .eot(eot),
    .pass(fm_pass), .fail(fm_fail), .busy(fm_busy), .evt_count(fm_cnt),
    .pass_total(fm_pt), .fail_total(fm_ft), .drop_total(fm_dt));

  rep_window_monitor #(.MIN(1), .MAX(3), .TIMEOUT(16), .STRICT(1)) u_st (
    .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .evt(evt), .eot(eot),
    .pass(st_pass), .fail(st_fail), .busy(st_busy), .evt_count(st_cnt),
    .pass_total(st_pt), .fail_total(st_ft), .drop_total(st_dt));

  rep_window_monitor #(.MIN(2), .MAX(3), .TIMEOUT(16), .STRICT(0)) u_m2 (
    .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .evt(evt), .eot(eot),
    .pass(m2_pass), .fail(m2_fail), .busy(m2_busy), .evt_count(m2_cnt),
    .pass_total(m2_pt), .fail_total(m2_ft), .drop_total(m2_dt));

  typedef struct {
    logic       trig;
    logic       evt;
    logic       fm_pass, fm_fail, fm_busy;
    logic [2:0] fm_cnt;
    logic       st_pass, st_fail, st_busy;
    logic [2:0] st_cnt;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic t, input logic e,
                              input logic fp, input logic ff, input logic fb, input logic [2:0] fc,
                              input logic sp, input logic sf, input logic sb, input logic [2:0] sc);
    vec_t v;
    v.trig = t; v.evt = e;
    v.fm_pass = fp; v.fm_fail = ff; v.fm_busy = fb; v.fm_cnt = fc;
    v.st_pass = sp; v.st_fail = sf; v.st_busy = sb; v.st_cnt = sc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic e, input logic o, input logic n);
    trig = t; evt = e; eot = o; en = n;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trig = 1'b0; evt = 1'b0; eot = 1'b0; en = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    // Scenario A table: trig rise at edge 2, evt at 3/5/7.
    tbl[0] = mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 3'd0);
    tbl[1] = mk(1, 0, 0, 0, 1, 3'd0, 0, 0, 1, 3'd0);
    tbl[2] = mk(0, 1, 1, 0, 0, 3'd1, 0, 0, 1, 3'd1);
    tbl[3] = mk(0, 0, 0, 0, 0, 3'd1, 0, 0, 1, 3'd1);
    tbl[4] = mk(0, 1, 0, 0, 0, 3'd1, 0, 0, 1, 3'd2);
    tbl[5] = mk(0, 0, 0, 0, 0, 3'd1, 0, 0, 1, 3'd2);
    tbl[6] = mk(0, 1, 0, 0, 0, 3'd1, 0, 0, 1, 3'd3);
    for (int i = 7; i < 16; i++) tbl[i] = mk(0, 0, 0, 0, 0, 3'd1, 0, 0, 1, 3'd3);
    tbl[16] = mk(0, 0, 0, 0, 0, 3'd1, 1, 0, 0, 3'd3);
    tbl[17] = mk(0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 3'd3);

    do_reset();
    check("reset_fm_busy", fm_busy, 0);
    check("reset_fm_cnt", fm_cnt, 0);
    check("reset_st_pass", st_pass, 0);
    check("reset_m2_totals", {m2_pt, m2_ft}, 0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].trig, tbl[i].evt, 1'b0, 1'b1);
      check("tblA_fm", {fm_pass, fm_fail, fm_busy, fm_cnt},
            {tbl[i].fm_pass, tbl[i].fm_fail, tbl[i].fm_busy, tbl[i].fm_cnt});
      check("tblA_st", {st_pass, st_fail, st_busy, st_cnt},
            {tbl[i].st_pass, tbl[i].st_fail, tbl[i].st_busy, tbl[i].st_cnt});
    end
    check("A_fm_totals", {fm_pt, fm_ft, fm_dt}, {16'd1, 16'd0, 16'd0});
    check("A_st_totals", {st_pt, st_ft, st_dt}, {16'd1, 16'd0, 16'd0});
    check("A_m2_pass_total", m2_pt, 16'd1);

    // Scenario B: strict, 4th evt at edge 9 exceeds MAX.
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      step(e == 2, (e == 3) || (e == 5) || (e == 7) || (e == 9), 1'b0, 1'b1);
      if (e == 8) check("B_st_pending", {st_fail, st_busy, st_cnt}, {1'b0, 1'b1, 3'd3});
      if (e == 9) check("B_st_fail", {st_pass, st_fail, st_busy, st_cnt}, {1'b0, 1'b1, 1'b0, 3'd4});
      if (e == 10) check("B_st_fail_pulse_end", st_fail, 0);
    end
    check("B_st_totals", {st_pt, st_ft}, {16'd0, 16'd1});

    // Scenario C: no evt, window times out at edge 17.
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      step(e == 2, 1'b0, 1'b0, 1'b1);
      if (e == 16) check("C_busy_16", {fm_busy, st_busy, m2_busy, fm_fail}, 4'b1110);
      if (e == 17) check("C_fail_17", {fm_fail, st_fail, m2_fail, fm_busy, fm_pass}, 5'b11100);
      if (e == 18) check("C_fail_pulse_end", {fm_fail, st_fail, m2_fail}, 3'b000);
    end
    check("C_fm_totals", {fm_pt, fm_ft, fm_cnt}, {16'd0, 16'd1, 3'd0});

    // Scenario D: eot at edge 5 closes the pending window.
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      step(e == 2, 1'b0, e == 5, 1'b1);
      if (e == 4) check("D_busy_4", {fm_busy, st_busy, fm_fail}, 3'b110);
      if (e == 5) check("D_fail_5", {fm_fail, st_fail, m2_fail, fm_busy}, 4'b1110);
    end
    check("D_st_totals", {st_pt, st_ft}, {16'd0, 16'd1});

    // Scenario E: MIN=2, evt on trigger edge and last window edge; re-rise at 4.
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      step((e == 2) || (e == 4), (e == 2) || (e == 17), 1'b0, 1'b1);
      if (e == 2) check("E_m2_start", {m2_busy, m2_cnt}, {1'b1, 3'd1});
      if (e == 4) check("E_m2_drop", {m2_busy, m2_dt}, {1'b1, 16'd1});
      if (e == 16) check("E_m2_pending", {m2_pass, m2_fail, m2_busy}, 3'b001);
      if (e == 17) check("E_m2_pass_last", {m2_pass, m2_fail, m2_busy, m2_cnt}, {3'b100, 3'd2});
      if (e == 18) check("E_m2_pulse_end", m2_pass, 0);
    end
    check("E_m2_totals", {m2_pt, m2_ft, m2_dt}, {16'd1, 16'd0, 16'd1});

    // Scenario F: en dropped while busy aborts without verdict.
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      step(e == 2, e == 3, 1'b0, e != 4);
    end
    check("F_st_abort", {st_pass, st_fail, st_busy, st_cnt}, {3'b000, 3'd1});
    check("F_st_totals", {st_pt, st_ft}, {16'd0, 16'd0});

    // Scenario G: async reset mid-window, trig held high through release.
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      step((e == 2) || (e >= 5), e == 3, 1'b0, 1'b1);
    end
    check("G_pre_reset", {fm_busy, fm_pt}, {1'b1, 16'd1});
    #2 rst_n = 1'b0;
    #1;
    check("G_async_reset", {fm_busy, fm_pass, fm_cnt, fm_pt, st_busy}, 0);
    #2 rst_n = 1'b1;
    edge_n = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("G_rearm_after_release", {fm_busy, fm_cnt}, {1'b1, 3'd0});
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("G_no_second_rise", {fm_busy, fm_dt}, {1'b1, 16'd0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
